// File: rtl/axi_pkg.sv
// Shared AXI definitions for the error responder: response codes, data width
// and the write/read FSM state encodings.
package axi_pkg;

  localparam int CPU_WIDTH = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/axi_error_slave.sv
// AXI4 default responder for unmapped addresses: accepts every burst and
// terminates it with an error response. One outstanding transfer per direction.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, swallowing beats until wlast
// W_RESP | bvalid high with the error response
// R_IDLE | arready high, waiting for a read address
// R_DATA | rvalid high, returning arlen+1 error beats
module axi_error_slave
  import axi_pkg::*;
#(
  parameter logic [1:0]           RESP      = RESP_DECERR,
  parameter logic [CPU_WIDTH-1:0] RDATA_PAT = 32'hDEAD_BEEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [CPU_WIDTH-1:0]   awaddr,
  input  logic [3:0]             awid,
  input  logic [7:0]             awlen,
  input  logic [2:0]             awsize,
  input  logic [1:0]             awburst,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [CPU_WIDTH-1:0]   wdata,
  input  logic [CPU_WIDTH/8-1:0] wstrb,
  input  logic                   wlast,
  output logic                   bvalid,
  input  logic                   bready,
  output logic [1:0]             bresp,
  output logic [3:0]             bid,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [CPU_WIDTH-1:0]   araddr,
  input  logic [3:0]             arid,
  input  logic [7:0]             arlen,
  input  logic [2:0]             arsize,
  input  logic [1:0]             arburst,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [CPU_WIDTH-1:0]   rdata,
  output logic [1:0]             rresp,
  output logic                   rlast,
  output logic [3:0]             rid,
  output logic                   wlast_err
);

  // Address attributes and write payload are irrelevant to an error responder.
  logic unused_ok;
  assign unused_ok = ^{awaddr, awsize, awburst, wdata, wstrb, araddr, arsize, arburst};

  w_state_e   w_state, w_next;
  logic [7:0] w_cnt, awlen_q;
  logic [3:0] awid_q;
  logic       aw_hs, w_hs, b_hs;
  logic       awready_d, wready_d, bvalid_d;
  logic [1:0] bresp_d;
  logic [3:0] bid_d;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      w_state   <= W_IDLE;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= 2'b00;
      bid       <= 4'h0;
      w_cnt     <= 8'd0;
      awlen_q   <= 8'd0;
      awid_q    <= 4'h0;
      wlast_err <= 1'b0;
    end else begin
      w_state   <= w_next;
      awready   <= awready_d;
      wready    <= wready_d;
      bvalid    <= bvalid_d;
      bresp     <= bresp_d;
      bid       <= bid_d;
      wlast_err <= w_hs && (wlast != (w_cnt == awlen_q));
      if (aw_hs) begin
        awid_q  <= awid;
        awlen_q <= awlen;
        w_cnt   <= 8'd0;
      end else if (w_hs) begin
        w_cnt <= w_cnt + 8'd1;
      end
    end
  end

  // The burst ends on wlast alone; a length mismatch only raises wlast_err.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && wlast) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered.
  always_comb begin
    awready_d = (w_next == W_IDLE);
    wready_d  = (w_next == W_DATA);
    bvalid_d  = (w_next == W_RESP);
    bresp_d   = bvalid_d ? RESP : RESP_OKAY;
    bid_d     = bvalid_d ? awid_q : 4'h0;
  end

  r_state_e   r_state, r_next;
  logic [7:0] r_cnt, r_cnt_nx, arlen_q, arlen_nx;
  logic [3:0] arid_q, arid_nx;
  logic       ar_hs, r_hs;
  logic       arready_d, rvalid_d, rlast_d;
  logic [CPU_WIDTH-1:0] rdata_d;
  logic [1:0] rresp_d;
  logic [3:0] rid_d;

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rdata   <= '0;
      rresp   <= 2'b00;
      rid     <= 4'h0;
      r_cnt   <= 8'd0;
      arlen_q <= 8'd0;
      arid_q  <= 4'h0;
    end else begin
      r_state <= r_next;
      arready <= arready_d;
      rvalid  <= rvalid_d;
      rlast   <= rlast_d;
      rdata   <= rdata_d;
      rresp   <= rresp_d;
      rid     <= rid_d;
      r_cnt   <= r_cnt_nx;
      arlen_q <= arlen_nx;
      arid_q  <= arid_nx;
    end
  end

  always_comb begin
    r_next   = r_state;
    r_cnt_nx = r_cnt;
    arlen_nx = arlen_q;
    arid_nx  = arid_q;
    if (ar_hs) begin
      r_cnt_nx = 8'd0;
      arlen_nx = arlen;
      arid_nx  = arid;
    end else if (r_hs) begin
      r_cnt_nx = r_cnt + 8'd1;
    end
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // rlast looks at the upcoming beat index so it lines up with the registered rvalid.
  always_comb begin
    arready_d = (r_next == R_IDLE);
    rvalid_d  = (r_next == R_DATA);
    rlast_d   = rvalid_d && (r_cnt_nx == arlen_nx);
    rdata_d   = rvalid_d ? RDATA_PAT : '0;
    rresp_d   = rvalid_d ? RESP : RESP_OKAY;
    rid_d     = rvalid_d ? arid_nx : 4'h0;
  end

endmodule

// File: tb/tb_axi_error_slave.sv
// Randomized bench for axi_error_slave: transaction-level model of the expected
// error responses, beat counts, IDs and handshake latencies.
module tb_axi_error_slave;
  import axi_pkg::*;

  logic                   i_clk = 1'b0;
  logic                   i_rst_n = 1'b0;
  logic                   awvalid = 1'b0, awready;
  logic [CPU_WIDTH-1:0]   awaddr = '0;
  logic [3:0]             awid = '0;
  logic [7:0]             awlen = '0;
  logic [2:0]             awsize = '0;
  logic [1:0]             awburst = '0;
  logic                   wvalid = 1'b0, wready;
  logic [CPU_WIDTH-1:0]   wdata = '0;
  logic [CPU_WIDTH/8-1:0] wstrb = '0;
  logic                   wlast = 1'b0;
  logic                   bvalid, bready = 1'b0;
  logic [1:0]             bresp;
  logic [3:0]             bid;
  logic                   arvalid = 1'b0, arready;
  logic [CPU_WIDTH-1:0]   araddr = '0;
  logic [3:0]             arid = '0;
  logic [7:0]             arlen = '0;
  logic [2:0]             arsize = '0;
  logic [1:0]             arburst = '0;
  logic                   rvalid, rready = 1'b0;
  logic [CPU_WIDTH-1:0]   rdata;
  logic [1:0]             rresp;
  logic                   rlast;
  logic [3:0]             rid;
  logic                   wlast_err;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0]  EXP_RESP = 2'b11;
  localparam logic [31:0] EXP_DATA = 32'hDEADBEEF;

  axi_error_slave dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid),
    .wlast_err(wlast_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // wl_beat: index of the beat carrying wlast (len for a well-formed burst).
  task automatic do_write(input logic [3:0] id, input logic [7:0] len, input int wl_beat,
                          input int b_delay);
    int k;
    awid = id; awlen = len; awaddr = $urandom; awsize = 3'd2; awburst = 2'b01;
    awvalid = 1'b1;
    k = 0;
    while (!awready && k < 20) begin tick(); k++; end
    chk("aw_accept", awready, 1);
    tick();
    awvalid = 1'b0;
    chk("awready_busy", awready, 0);
    chk("wready_on", wready, 1);
    for (int b = 0; b <= wl_beat; b++) begin
      if ($urandom_range(3) == 0) begin
        wvalid = 1'b0;
        tick();
        chk("w_gap_err", wlast_err, 0);
      end
      wvalid = 1'b1; wlast = (b == wl_beat); wdata = $urandom; wstrb = 4'($urandom);
      chk("wready_beat", wready, 1);
      tick();
      chk("wlast_err", wlast_err, ((b == wl_beat) != (b == int'(len))));
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid", bvalid, 1);
    chk("bid", bid, id);
    chk("bresp", bresp, EXP_RESP);
    chk("wready_off", wready, 0);
    for (int d = 0; d < b_delay; d++) begin
      tick();
      chk("b_hold", bvalid, 1);
      chk("b_hold_id", bid, id);
      chk("awready_hold", awready, 0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("b_done", bvalid, 0);
    chk("awready_back", awready, 1);
    chk("wlast_err_clr", wlast_err, 0);
  endtask

  // mode 0: rready high, 1: toggle 1/0, 2: random
  task automatic do_read(input logic [3:0] id, input logic [7:0] len, input int mode);
    int k, idx, cyc;
    arid = id; arlen = len; araddr = $urandom; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1;
    k = 0;
    while (!arready && k < 20) begin tick(); k++; end
    chk("ar_accept", arready, 1);
    tick();
    arvalid = 1'b0;
    idx = 0; cyc = 0;
    while (idx <= int'(len) && cyc < 4 * (int'(len) + 1) + 10) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = (cyc % 2 == 0);
        default: rready = ($urandom_range(1) == 1) || (cyc % 4 == 3);
      endcase
      chk("rvalid", rvalid, 1);
      chk("rdata", rdata, EXP_DATA);
      chk("rresp", rresp, EXP_RESP);
      chk("rid", rid, id);
      chk("rlast", rlast, (idx == int'(len)));
      chk("arready_busy", arready, 0);
      tick();
      if (rready) idx++;
      cyc++;
    end
    rready = 1'b0;
    chk("r_beats", idx, int'(len) + 1);
    chk("r_end_rvalid", rvalid, 0);
    chk("r_end_arready", arready, 1);
  endtask

  initial begin
    int len, wl, sel;
    logic [3:0] wid, rd_id;

    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_wlast_err", wlast_err, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bid", bid, 0);
    chk("rst_rid", rid, 0);
    chk("rst_rdata", rdata, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    chk("rel_awready", awready, 1);
    chk("rel_arready", arready, 1);
    chk("rel_wready", wready, 0);

    // W beats ahead of AW must be stalled
    wvalid = 1'b1; wlast = 1'b1;
    repeat (3) begin
      tick();
      chk("w_early_stall", wready, 0);
      chk("w_early_bvalid", bvalid, 0);
    end
    wvalid = 1'b0; wlast = 1'b0;

    do_write(4'h3, 8'd0, 0, 0);
    do_read(4'h5, 8'd3, 0);
    do_read(4'hA, 8'd7, 1);
    do_write(4'h6, 8'd3, 1, 2);
    do_write(4'h7, 8'd3, 5, 1);

    fork
      do_write(4'hC, 8'd1, 1, 1);
      do_read(4'hE, 8'd255, 0);
    join

    for (int t = 0; t < 24; t++) begin
      len = $urandom_range(0, 15);
      wl = len;
      sel = $urandom_range(0, 5);
      if (sel == 0) wl = len + 1;
      else if (sel == 1 && len > 0) wl = $urandom_range(0, len - 1);
      wid = 4'($urandom);
      rd_id = 4'($urandom);
      case ($urandom_range(0, 2))
        0: do_write(wid, 8'(len), wl, $urandom_range(0, 3));
        1: do_read(rd_id, 8'(len), $urandom_range(0, 2));
        default: fork
          do_write(wid, 8'(len), wl, $urandom_range(0, 3));
          do_read(rd_id, 8'($urandom_range(0, 31)), $urandom_range(0, 2));
        join
      endcase
    end

    // reset in the middle of a read burst
    arid = 4'h9; arlen = 8'd7; arvalid = 1'b1;
    chk("mid_ar_ready", arready, 1);
    tick();
    arvalid = 1'b0; rready = 1'b1;
    chk("mid_rvalid0", rvalid, 1);
    tick();
    tick();
    chk("mid_rvalid2", rvalid, 1);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_arready", arready, 0);
    rready = 1'b0;
    tick();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    rready = 1'b1; bready = 1'b1;
    repeat (4) begin
      tick();
      chk("post_rst_arready", arready, 1);
      chk("post_rst_awready", awready, 1);
      chk("post_rst_rvalid", rvalid, 0);
      chk("post_rst_bvalid", bvalid, 0);
    end
    rready = 1'b0; bready = 1'b0;
    do_read(4'h2, 8'd2, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_error_slave.md
# axi_error_slave

AXI4 default responder that terminates every transaction routed to it with an error response. It sits behind the crossbar/address decoder on the unmapped-address port, so that a CPU access to a hole in the memory map completes cleanly with DECERR (or SLVERR) instead of hanging the bus. It is the producer of the non-OKAY BRESP/RRESP values that the bus access-fault monitor flags. Read and write paths are independent: one outstanding transaction per direction.

## Interface
- RESP, 2'b11, response code driven on bresp/rresp (DECERR; 2'b10 for SLVERR)
- RDATA_PAT, `CPU_WIDTH'hDEAD_BEEF, constant value driven on rdata for every error beat
- i_clk  in  1  clock; all state changes on rising edge
- i_rst_n  in  1  reset; asynchronous, active-low
- awvalid, awready  in/out  1  AW handshake; awaddr `CPU_WIDTH, awid 4, awlen 8, awsize 3, awburst 2 (inputs)
- wvalid, wready  in/out  1  W handshake; wdata `CPU_WIDTH, wstrb `CPU_WIDTH/8, wlast 1 (inputs, data ignored)
- bvalid, bready  out/in  1  B handshake; bresp 2, bid 4 (outputs)
- arvalid, arready  in/out  1  AR handshake; araddr `CPU_WIDTH, arid 4, arlen 8, arsize 3, arburst 2 (inputs)
- rvalid, rready  out/in  1  R handshake; rdata `CPU_WIDTH, rresp 2, rlast 1, rid 4 (outputs)
- wlast_err  out  1  one-cycle pulse: wlast seen on a beat other than beat awlen, or beat awlen accepted without wlast

## Operation
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1; on awvalid&&awready capture awid, awlen, clear beat counter, go W_DATA.
  - W_DATA: wready=1; every wvalid&&wready increments counter; on handshake with wlast go W_RESP. Burst always ends on wlast, never on counter alone.
  - W_RESP: bvalid=1, bid=captured awid, bresp=RESP; on bready go W_IDLE.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1; on handshake capture arid, arlen, clear counter, go R_DATA.
  - R_DATA: rvalid=1, rdata=RDATA_PAT, rresp=RESP, rid=captured arid, rlast=(counter==arlen); each rvalid&&rready increments; handshake with rlast returns to R_IDLE.
- Exactly arlen+1 R beats per AR (1..256); counter 8 bits, no wrap possible inside a burst.
- awaddr/araddr, awsize/arsize, awburst/arburst, wdata, wstrb accepted and ignored.
- wlast_err: asserted the cycle after the offending W handshake.
- All outputs held stable while valid and not ready (AXI stability rule).

## Timing
- Reset (i_rst_n low, asynchronous): both FSMs to IDLE; awready, wready, arready, bvalid, rvalid, rlast, wlast_err = 0; bresp, rresp, bid, rid, rdata = 0. Ready/valid are registered outputs.
- First cycle after reset release: awready=1, arready=1.
- AW handshake cycle N -> wready=1 from N+1; awready=0 from N+1 until back in W_IDLE.
- wlast handshake cycle N -> wready=0, bvalid=1 from N+1. bready handshake cycle M -> awready=1 from M+1.
- AR handshake cycle N -> rvalid=1 with first beat from N+1. With rready held high, one beat per cycle, last beat at N+1+arlen; arready=1 from N+2+arlen.
- W beats presented before AW are stalled (wready=0), not dropped.
- Read and write may be active in the same cycle with no interaction.
- Reset asserted mid-burst: burst abandoned, valids drop immediately, no response issued after release.

## Structure
- Shared package axi_pkg: response codes (RESP_OKAY 2'b00, RESP_EXOKAY 2'b01, RESP_SLVERR 2'b10, RESP_DECERR 2'b11), write and read state encodings.
- No sub-module; two independent sequential processes (write path, read path) in one module.

## Test plan
- AW id=4'h3 len=0, single W with wlast -> one cycle later bvalid, bid=4'h3, bresp=2'b11; awready returns after bready.
- AR id=4'h5 len=3, rready high -> 4 consecutive beats, rdata=32'hDEADBEEF, rresp=2'b11, rid=4'h5, rlast only on 4th; arready=1 two cycles after AR+3.
- AR len=7 with rready toggled 1/0 -> exactly 8 beats, rlast/rdata held stable across stalls.
- AW len=3, wlast on beat 1 -> wlast_err pulse, B response issued after that beat; second run with no wlast on beat 3 -> wlast_err pulse, wready stays high until wlast.
- Concurrent AW len=1 and AR len=255 -> B and 256 R beats both complete, IDs correct, no cross-channel stall.
- i_rst_n dropped during R beat 2 of len=7 -> rvalid=0 in same cycle; after release arready=1, no stray R or B beats.
